// File: rtl/prog_loader.sv
// Boot loader: parses a length-prefixed little-endian byte stream into 32-bit
// instruction-memory writes, verifies an XOR checksum, then releases the core.
module prog_loader #(
    parameter int          MAX_WORDS = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic [15:0] words_loaded,
    output logic        core_run,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    state_t      state;
    state_t      next_state;
    logic [7:0]  len_lo;
    logic [15:0] word_count;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic [7:0]  checksum;
    logic        xfer;
    logic [15:0] len_in;

    assign in_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                      (state == S_DATA)   || (state == S_CHK);
    assign xfer     = in_valid && in_ready;
    assign len_in   = {in_data, len_lo};
    assign imem_we  = (state == S_WRITE);
    assign done     = (state == S_DONE);
    assign err      = (state == S_ERR);
    assign core_run = done;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_LEN_LO;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_LEN_LO: begin
                if (xfer) next_state = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (xfer) begin
                    if (len_in == 16'd0)     next_state = S_CHK;
                    else if (len_in > MAX_N) next_state = S_ERR;
                    else                     next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer && byte_idx == 2'd3) next_state = S_WRITE;
            end
            S_WRITE: begin
                if (16'(words_loaded + 16'd1) == word_count) next_state = S_CHK;
                else                                           next_state = S_DATA;
            end
            S_CHK: begin
                if (xfer) next_state = (in_data == checksum) ? S_DONE : S_ERR;
            end
            S_DONE:  next_state = S_DONE;
            S_ERR:   next_state = S_ERR;
            default: next_state = S_ERR;
        endcase
    end

    // Address and data are registered on the word's last byte so they are
    // already stable throughout the single WRITE cycle and hold afterwards.
    always_ff @(posedge CLK) begin
        if (RST) begin
            len_lo       <= 8'h00;
            word_count   <= 16'h0000;
            byte_idx     <= 2'd0;
            word_buf     <= 24'h000000;
            checksum     <= 8'h00;
            words_loaded <= 16'h0000;
            imem_addr    <= 32'h0000_0000;
            imem_wdata   <= 32'h0000_0000;
        end else begin
            case (state)
                S_LEN_LO: begin
                    if (xfer) len_lo <= in_data;
                end
                S_LEN_HI: begin
                    if (xfer) word_count <= len_in;
                end
                S_DATA: begin
                    if (xfer) begin
                        checksum <= checksum ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= in_data;
                            2'd1: word_buf[15:8]  <= in_data;
                            2'd2: word_buf[23:16] <= in_data;
                            default: begin
                                imem_wdata <= {in_data, word_buf};
                                imem_addr  <= BASE_ADDR + {14'b0, words_loaded, 2'b00};
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    words_loaded <= words_loaded + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized and directed bench for prog_loader; expected writes and final
// status come from a stream-level model of the load format.
module tb_prog_loader;

    localparam int          MAX_WORDS = 64;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [63:0] write_q_t[$];

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [15:0] words_loaded;
    logic        core_run;
    logic        done;
    logic        err;

    int       numChecks = 0;
    int       numErrors = 0;
    write_q_t captured;

    prog_loader #(.MAX_WORDS(MAX_WORDS), .BASE_ADDR(BASE_ADDR)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .words_loaded(words_loaded),
        .core_run(core_run), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numErrors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Records every write pulse and watches the invariants that hold each cycle.
    always @(negedge CLK) begin
        if (imem_we) begin
            captured.push_back({imem_addr, imem_wdata});
            checkOutput("ready_in_write", 64'(in_ready), 64'd0);
        end
        if (done || err) checkOutput("done_err_excl", 64'(done & err), 64'd0);
    end

    function automatic byte_q_t makeStream(input int n, input bit corrupt);
        byte_q_t    s;
        logic [15:0] n16;
        logic [7:0]  chk;
        logic [7:0]  b;
        n16 = 16'(n);
        s.push_back(n16[7:0]);
        s.push_back(n16[15:8]);
        if (n > MAX_WORDS) return s;
        chk = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            s.push_back(b);
            chk ^= b;
        end
        if (corrupt) s.push_back(chk ^ 8'($urandom_range(255, 1)));
        else         s.push_back(chk);
        return s;
    endfunction

    function automatic void modelLoad(input byte_q_t s, output write_q_t w, output logic expDone,
                                      output logic expErr, output logic [15:0] expWords);
        int          n;
        int          p;
        logic [7:0]  chk;
        logic [31:0] word;
        w = {};
        n = int'({s[1], s[0]});
        if (n > MAX_WORDS) begin
            expDone  = 1'b0;
            expErr   = 1'b1;
            expWords = 16'd0;
            return;
        end
        chk = 8'h00;
        for (int i = 0; i < n; i++) begin
            p    = 2 + 4 * i;
            word = {s[p + 3], s[p + 2], s[p + 1], s[p]};
            chk  = chk ^ s[p] ^ s[p + 1] ^ s[p + 2] ^ s[p + 3];
            w.push_back({BASE_ADDR + 32'(4 * i), word});
        end
        expWords = 16'(n);
        expDone  = (s[2 + 4 * n] == chk);
        expErr   = !expDone;
    endfunction

    task automatic doReset(input string tag);
        RST      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        @(negedge CLK);
        RST      = 1'b0;
        in_valid = 1'b0;
        checkOutput({tag, "_rst_ready"}, 64'(in_ready), 64'd1);
        checkOutput({tag, "_rst_we"}, 64'(imem_we), 64'd0);
        checkOutput({tag, "_rst_addr"}, 64'(imem_addr), 64'd0);
        checkOutput({tag, "_rst_wdata"}, 64'(imem_wdata), 64'd0);
        checkOutput({tag, "_rst_words"}, 64'(words_loaded), 64'd0);
        checkOutput({tag, "_rst_run"}, 64'(core_run), 64'd0);
        checkOutput({tag, "_rst_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_rst_err"}, 64'(err), 64'd0);
        captured.delete();
    endtask

    // Sends each byte after gmin..gmax idle cycles; returns one cycle after the last transfer.
    task automatic applyStimulus(input byte_q_t s, input int gmin, input int gmax);
        foreach (s[i]) begin
            int g;
            int waits;
            g = $urandom_range(gmax, gmin);
            repeat (g) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge CLK);
            end
            in_valid = 1'b1;
            in_data  = s[i];
            waits    = 0;
            while (!in_ready && waits < 16) begin
                @(negedge CLK);
                waits++;
            end
            if (!in_ready) begin
                checkOutput("ready_timeout", 64'd0, 64'd1);
                in_valid = 1'b0;
                return;
            end
            @(negedge CLK);
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic checkLoad(input byte_q_t s, input string tag);
        write_q_t    expWrites;
        logic        expDone;
        logic        expErr;
        logic [15:0] expWords;
        int          cnt;
        modelLoad(s, expWrites, expDone, expErr, expWords);
        checkOutput({tag, "_done"}, 64'(done), 64'(expDone));
        checkOutput({tag, "_err"}, 64'(err), 64'(expErr));
        checkOutput({tag, "_run"}, 64'(core_run), 64'(expDone));
        checkOutput({tag, "_words"}, 64'(words_loaded), 64'(expWords));
        checkOutput({tag, "_ready_end"}, 64'(in_ready), 64'd0);
        checkOutput({tag, "_we_end"}, 64'(imem_we), 64'd0);
        @(negedge CLK);
        checkOutput({tag, "_nwrites"}, 64'(captured.size()), 64'(expWrites.size()));
        cnt = (captured.size() < expWrites.size()) ? captured.size() : expWrites.size();
        for (int i = 0; i < cnt; i++) checkOutput({tag, "_write"}, captured[i], expWrites[i]);
        repeat (3) @(negedge CLK);
        checkOutput({tag, "_done_hold"}, 64'(done), 64'(expDone));
        checkOutput({tag, "_err_hold"}, 64'(err), 64'(expErr));
    endtask

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        byte_q_t spec34;
        byte_q_t s;
        int      n;
        spec34 = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00,
                   8'h93, 8'h01, 8'hC0, 8'h00, 8'h10};
        RST      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(negedge CLK);
        doReset("init");

        applyStimulus(spec34, 0, 0);
        checkLoad(spec34, "req34");

        doReset("req35");
        applyStimulus(spec34, 3, 3);
        checkLoad(spec34, "req35");

        doReset("req36");
        s = '{8'h41, 8'h00};
        applyStimulus(s, 0, 0);
        checkLoad(s, "req36");

        doReset("req37");
        s = spec34;
        s[s.size() - 1] = 8'h11;
        applyStimulus(s, 0, 0);
        checkLoad(s, "req37");

        doReset("req38a");
        s = '{8'h00, 8'h00, 8'h00};
        applyStimulus(s, 0, 1);
        checkLoad(s, "req38a");

        doReset("req38b");
        s = '{8'h00, 8'h00, 8'hFF};
        applyStimulus(s, 0, 1);
        checkLoad(s, "req38b");

        doReset("req39a");
        s = spec34[0:5];
        applyStimulus(s, 0, 0);
        @(negedge CLK);
        checkOutput("req39_partial_writes", 64'(captured.size()), 64'd1);
        doReset("req39b");
        applyStimulus(spec34, 0, 0);
        checkLoad(spec34, "req39");

        doReset("max");
        s = makeStream(MAX_WORDS, 1'b0);
        applyStimulus(s, 0, 0);
        checkLoad(s, "max_words");

        for (int t = 0; t < 40; t++) begin
            doReset("rand");
            n = ($urandom_range(9, 0) == 0) ? int'($urandom_range(300, 65)) : int'($urandom_range(6, 0));
            s = makeStream(n, $urandom_range(3, 0) == 0);
            applyStimulus(s, 0, $urandom_range(3, 0));
            checkLoad(s, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", numChecks, numErrors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter MAX_WORDS, default 64: maximum instruction words accepted per load.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first instruction word.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream byte-stream valid.
REQ-006 in_data  input  8  upstream byte.
REQ-007 in_ready  output  1  loader can accept a byte this cycle.
REQ-008 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr  output  32  byte address of the word being written (word-aligned).
REQ-010 imem_wdata  output  32  instruction word being written.
REQ-011 words_loaded  output  16  count of words written in the current load.
REQ-012 core_run  output  1  1 = core released to execute; 0 = core held.
REQ-013 done  output  1  load completed with a good checksum.
REQ-014 err  output  1  load aborted.

Function
REQ-015 Byte transfer occurs at a rising edge with in_valid=1 and in_ready=1; otherwise the byte is ignored and no state changes.
REQ-016 Stream format: LEN_LO, LEN_HI (16-bit little-endian word count N), then 4*N data bytes, then one checksum byte.
REQ-017 Words are little-endian: first byte -> imem_wdata[7:0], fourth byte -> [31:24].
REQ-018 States: LEN_LO, LEN_HI, DATA, WRITE, CHK, DONE, ERR; in_ready=1 only in LEN_LO, LEN_HI, DATA and CHK.
REQ-019 LEN_LO -> LEN_HI on transfer; the byte is latched.
REQ-020 LEN_HI on transfer: N=0 -> CHK; N>MAX_WORDS -> ERR; otherwise -> DATA.
REQ-021 DATA: the fourth byte of a word -> WRITE; earlier bytes stay in DATA.
REQ-022 WRITE lasts exactly one cycle: imem_we=1, imem_addr=BASE_ADDR+4*words_loaded (32-bit wrap), imem_wdata=assembled word; words_loaded increments at the end of the cycle. Next state is CHK if words_loaded+1==N, else DATA.
REQ-023 imem_we=0 in all states other than WRITE; imem_addr and imem_wdata hold their last values outside WRITE.
REQ-024 Checksum: 8-bit XOR of all 4*N data bytes; LEN bytes are excluded; the initial value is 8'h00.
REQ-025 CHK on transfer: byte equals checksum -> DONE; otherwise -> ERR.
REQ-026 DONE: done=1 and core_run=1, both asserted in the cycle after the checksum transfer; held until RST.
REQ-027 ERR: err=1, core_run=0, done=0; held until RST; no further memory writes.
REQ-028 done and err are never 1 simultaneously.
REQ-029 In DONE and ERR, input bytes are not accepted (in_ready=0) and in_valid is ignored.
REQ-030 Gaps in in_valid at any point do not change the written words, addresses or checksum.

Reset
REQ-031 RST=1 at a rising edge forces: state LEN_LO, in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, words_loaded=0, checksum=0, partial byte count=0, core_run=0, done=0, err=0.
REQ-032 RST takes priority over any transfer in the same cycle; the byte presented with RST is dropped.
REQ-033 RST mid-load abandons the load; words already written to memory are not erased; a fresh stream after RST deasserts loads normally.

Verification
REQ-034 Stream 02 00 | 13 01 50 00 | 93 01 C0 00 | 10 with in_valid held high -> two single-cycle writes: addr 0x0 data 0x00500113, then addr 0x4 data 0x00C00193; words_loaded=2; done=1 and core_run=1 one cycle after byte 0x10.
REQ-035 Same stream with in_valid deasserted for 3 cycles between every byte -> identical writes and final outputs; in_ready=0 in each WRITE cycle.
REQ-036 Stream 41 00 (N=65, MAX_WORDS=64) -> err=1 one cycle after the second byte; in_ready=0; no imem_we pulse; core_run=0.
REQ-037 Stream from REQ-034 with checksum byte 0x11 -> both writes occur; then err=1, done=0, core_run=0, words_loaded=2.
REQ-038 Stream 00 00 00 -> no writes; done=1, core_run=1; stream 00 00 FF -> err=1.
REQ-039 RST pulsed after the 6th byte of the REQ-034 stream -> all outputs at their reset values next cycle; the full REQ-034 stream then completes exactly as in REQ-034.
